// File: rtl/axi_tlb_cfg_writer_if.sv
// Command, response and register-request signals of the axi_tlb configuration writer.
// The slave modport is the writer's own view; master is the surrounding host/regfile side.
interface axi_tlb_cfg_writer_if #(
    parameter int unsigned NumEntries   = 8,
    parameter int unsigned PageWidth    = 36,
    parameter int unsigned RegAddrWidth = 32
);
    localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_op_i;
    logic [IdxW-1:0]         cmd_idx_i;
    logic [PageWidth-1:0]    cmd_first_i;
    logic [PageWidth-1:0]    cmd_last_i;
    logic [PageWidth-1:0]    cmd_base_i;
    logic                    cmd_valid_flag_i;
    logic                    cmd_ro_i;
    logic                    cmd_enable_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic                    rsp_error_o;
    logic                    busy_o;

    logic                    reg_valid_o;
    logic                    reg_write_o;
    logic [RegAddrWidth-1:0] reg_addr_o;
    logic [31:0]             reg_wdata_o;
    logic [3:0]              reg_wstrb_o;
    logic                    reg_ready_i;
    logic                    reg_error_i;
    logic [31:0]             reg_rdata_i;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_idx_i, cmd_first_i, cmd_last_i, cmd_base_i,
               cmd_valid_flag_i, cmd_ro_i, cmd_enable_i, rsp_ready_i,
               reg_ready_i, reg_error_i, reg_rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_error_o, busy_o,
               reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_idx_i, cmd_first_i, cmd_last_i, cmd_base_i,
               cmd_valid_flag_i, cmd_ro_i, cmd_enable_i, rsp_ready_i,
               reg_ready_i, reg_error_i, reg_rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_error_o, busy_o,
               reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );
endinterface

// File: rtl/axi_tlb_cfg_writer.sv
// Turns "write L1 entry" / "set enable" commands into ordered 32-bit register writes
// towards the axi_tlb configuration regfile, with one response per command.
module axi_tlb_cfg_writer #(
    parameter int unsigned             NumEntries   = 8,
    parameter int unsigned             PageWidth    = 36,
    parameter int unsigned             RegAddrWidth = 32,
    parameter logic [RegAddrWidth-1:0] EntryBase    = '0,
    parameter logic [RegAddrWidth-1:0] EnableAddr   = RegAddrWidth'('h100)
) (
    input logic                 clk_i,
    input logic                 rst_i,
    axi_tlb_cfg_writer_if.slave bus
);
    localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam logic [2:0]  LastEntryStep = 3'd7;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

    state_e               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic                 op_q, op_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [PageWidth-1:0] first_q, first_d;
    logic [PageWidth-1:0] last_q, last_d;
    logic [PageWidth-1:0] base_q, base_d;
    logic                 vflag_q, vflag_d;
    logic                 ro_q, ro_d;
    logic                 en_q, en_d;
    logic                 err_q, err_d;

    logic                    reg_valid_q, reg_valid_d;
    logic [RegAddrWidth-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]             reg_wdata_q, reg_wdata_d;

    logic idx_bad;
    logic last_step;
    logic unused_rdata;

    // Indices that fit in IdxW bits but lie beyond NumEntries are rejected without traffic.
    if ((1 << IdxW) > NumEntries) begin : g_idx_chk
        assign idx_bad = 32'(bus.cmd_idx_i) >= NumEntries;
    end else begin : g_idx_all_valid
        assign idx_bad = 1'b0;
    end

    function automatic logic [31:0] hi_word(logic [PageWidth-1:0] page);
        logic [63:0] wide;
        wide = 64'(page);
        return wide[63:32];
    endfunction

    // Step 0 and step 7 both hit the flags word: invalidate first, publish last.
    function automatic logic [RegAddrWidth-1:0] step_addr(logic op, logic [IdxW-1:0] idx,
                                                          logic [2:0] step);
        logic [RegAddrWidth-1:0] off;
        if (op) return EnableAddr;
        case (step)
            3'd0, 3'd7: off = RegAddrWidth'(8'h18);
            default:    off = RegAddrWidth'({step - 3'd1, 2'b00});
        endcase
        return EntryBase + (RegAddrWidth'(idx) << 5) + off;
    endfunction

    function automatic logic [31:0] step_wdata(logic op, logic [2:0] step,
                                               logic [PageWidth-1:0] first,
                                               logic [PageWidth-1:0] last,
                                               logic [PageWidth-1:0] base,
                                               logic vflag, logic ro, logic en);
        if (op) return {31'b0, en};
        case (step)
            3'd1:    return first[31:0];
            3'd2:    return hi_word(first);
            3'd3:    return last[31:0];
            3'd4:    return hi_word(last);
            3'd5:    return base[31:0];
            3'd6:    return hi_word(base);
            3'd7:    return {30'b0, ro, vflag};
            default: return 32'h0;
        endcase
    endfunction

    assign last_step = op_q || (step_q == LastEntryStep);

    // NOTE: state registers use non-blocking assignments so every _q updates from the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            step_q      <= '0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            base_q      <= '0;
            vflag_q     <= 1'b0;
            ro_q        <= 1'b0;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
            reg_valid_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            base_q      <= base_d;
            vflag_q     <= vflag_d;
            ro_q        <= ro_d;
            en_q        <= en_d;
            err_q       <= err_d;
            reg_valid_q <= reg_valid_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        op_d        = op_q;
        idx_d       = idx_q;
        first_d     = first_q;
        last_d      = last_q;
        base_d      = base_q;
        vflag_d     = vflag_q;
        ro_d        = ro_q;
        en_d        = en_q;
        err_d       = err_q;
        reg_valid_d = reg_valid_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    op_d    = bus.cmd_op_i;
                    idx_d   = bus.cmd_idx_i;
                    first_d = bus.cmd_first_i;
                    last_d  = bus.cmd_last_i;
                    base_d  = bus.cmd_base_i;
                    vflag_d = bus.cmd_valid_flag_i;
                    ro_d    = bus.cmd_ro_i;
                    en_d    = bus.cmd_enable_i;
                    step_d  = '0;
                    if (!bus.cmd_op_i && idx_bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        err_d       = 1'b0;
                        reg_valid_d = 1'b1;
                        reg_addr_d  = step_addr(bus.cmd_op_i, bus.cmd_idx_i, 3'd0);
                        reg_wdata_d = step_wdata(bus.cmd_op_i, 3'd0, bus.cmd_first_i,
                                                 bus.cmd_last_i, bus.cmd_base_i,
                                                 bus.cmd_valid_flag_i, bus.cmd_ro_i,
                                                 bus.cmd_enable_i);
                    end
                end
            end
            WRITE: begin
                if (reg_valid_q && bus.reg_ready_i) begin
                    if (bus.reg_error_i || last_step) begin
                        reg_valid_d = 1'b0;
                        state_d     = RESP;
                        err_d       = bus.reg_error_i;
                    end else begin
                        step_d      = step_q + 3'd1;
                        reg_addr_d  = step_addr(op_q, idx_q, step_q + 3'd1);
                        reg_wdata_d = step_wdata(op_q, step_q + 3'd1, first_q, last_q, base_q,
                                                 vflag_q, ro_q, en_q);
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready_o = (state_q == IDLE);
        bus.busy_o      = (state_q != IDLE);
        bus.rsp_valid_o = (state_q == RESP);
        bus.rsp_error_o = (state_q == RESP) && err_q;
    end

    assign bus.reg_valid_o = reg_valid_q;
    assign bus.reg_write_o = 1'b1;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign bus.reg_wstrb_o = 4'hF;
    assign unused_rdata    = ^bus.reg_rdata_i;
endmodule

// File: tb/tb_axi_tlb_cfg_writer.sv
// Self-checking bench for axi_tlb_cfg_writer: directed scenarios plus randomized commands
// checked against a list-of-writes reference model built from the register map.
module tb_axi_tlb_cfg_writer;
    // Six entries leave index codes 6 and 7 representable, so the out-of-range path is reachable.
    localparam int unsigned NumEntries   = 6;
    localparam int unsigned PageWidth    = 36;
    localparam int unsigned RegAddrWidth = 32;
    localparam logic [31:0] EntryBase    = 32'h0;
    localparam logic [31:0] EnableAddr   = 32'h100;
    localparam int          Budget       = 200;

    typedef struct {
        logic                 op;
        logic [2:0]           idx;
        logic [PageWidth-1:0] first;
        logic [PageWidth-1:0] last;
        logic [PageWidth-1:0] base;
        logic                 vflag;
        logic                 ro;
        logic                 en;
    } cmd_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  exp_q[$];

    always #5 clk_i = ~clk_i;

    axi_tlb_cfg_writer_if #(
        .NumEntries(NumEntries), .PageWidth(PageWidth), .RegAddrWidth(RegAddrWidth)
    ) bus ();

    axi_tlb_cfg_writer #(
        .NumEntries(NumEntries), .PageWidth(PageWidth), .RegAddrWidth(RegAddrWidth),
        .EntryBase(EntryBase), .EnableAddr(EnableAddr)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    // Reference: the full list of (address, data) writes a command must produce.
    function automatic void build_expected(input cmd_t c);
        logic [31:0] eb;
        logic [63:0] f, l, b;
        exp_q.delete();
        if (c.op) begin
            exp_q.push_back('{addr: EnableAddr, data: {31'b0, c.en}});
            return;
        end
        if (c.idx >= NumEntries) return;
        eb = EntryBase + 32'(c.idx) * 32;
        f  = 64'(c.first);
        l  = 64'(c.last);
        b  = 64'(c.base);
        exp_q.push_back('{addr: eb + 32'h18, data: 32'h0});
        exp_q.push_back('{addr: eb + 32'h00, data: f[31:0]});
        exp_q.push_back('{addr: eb + 32'h04, data: f[63:32]});
        exp_q.push_back('{addr: eb + 32'h08, data: l[31:0]});
        exp_q.push_back('{addr: eb + 32'h0C, data: l[63:32]});
        exp_q.push_back('{addr: eb + 32'h10, data: b[31:0]});
        exp_q.push_back('{addr: eb + 32'h14, data: b[63:32]});
        exp_q.push_back('{addr: eb + 32'h18, data: {30'b0, c.ro, c.vflag}});
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid_i      = 1'b0;
        bus.cmd_op_i         = 1'b0;
        bus.cmd_idx_i        = '0;
        bus.cmd_first_i      = '0;
        bus.cmd_last_i       = '0;
        bus.cmd_base_i       = '0;
        bus.cmd_valid_flag_i = 1'b0;
        bus.cmd_ro_i         = 1'b0;
        bus.cmd_enable_i     = 1'b0;
        bus.rsp_ready_i      = 1'b0;
        bus.reg_ready_i      = 1'b0;
        bus.reg_error_i      = 1'b0;
        bus.reg_rdata_i      = 32'h0;
    endtask

    // Issues one command (called at a negedge with the DUT idle) and checks the writes,
    // the response and the return to idle. err_step < 0 means no injected error.
    task automatic run_cmd(input string name, input cmd_t c, input int stall,
                           input int err_step, input int rsp_hold);
        int   cyc, k, stall_cnt, rsp_cyc, n_exp;
        bit   done, exp_err;
        build_expected(c);
        n_exp   = (err_step >= 0 && err_step < exp_q.size()) ? err_step + 1 : exp_q.size();
        exp_err = (c.op == 1'b0 && c.idx >= NumEntries) ||
                  (err_step >= 0 && err_step < exp_q.size());

        n_checks++;
        if (bus.cmd_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s cmd_ready_before: got %b expected 1", name, bus.cmd_ready_o);
        end
        bus.cmd_valid_i      = 1'b1;
        bus.cmd_op_i         = c.op;
        bus.cmd_idx_i        = c.idx;
        bus.cmd_first_i      = c.first;
        bus.cmd_last_i       = c.last;
        bus.cmd_base_i       = c.base;
        bus.cmd_valid_flag_i = c.vflag;
        bus.cmd_ro_i         = c.ro;
        bus.cmd_enable_i     = c.en;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b0;
        cyc = 1; k = 0; stall_cnt = 0; done = 0; rsp_cyc = 0;

        while (!done && cyc < Budget) begin
            n_checks++;
            if (bus.busy_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL %s busy/cmd_ready c%0d: got %b/%b expected 1/0",
                         name, cyc, bus.busy_o, bus.cmd_ready_o);
            end
            if (bus.rsp_valid_o === 1'b1) begin
                done    = 1;
                rsp_cyc = cyc;
            end else begin
                if (bus.reg_valid_o === 1'b1) begin
                    n_checks++;
                    if (k >= n_exp) begin
                        n_errors++;
                        $display("FAIL %s extra_write: got addr %h beyond %0d expected writes",
                                 name, bus.reg_addr_o, n_exp);
                    end else if (bus.reg_addr_o !== exp_q[k].addr ||
                                 bus.reg_wdata_o !== exp_q[k].data ||
                                 bus.reg_write_o !== 1'b1 || bus.reg_wstrb_o !== 4'hF) begin
                        n_errors++;
                        $display("FAIL %s write[%0d]: got %h=%h w%b s%h expected %h=%h w1 sf",
                                 name, k, bus.reg_addr_o, bus.reg_wdata_o, bus.reg_write_o,
                                 bus.reg_wstrb_o, exp_q[k].addr, exp_q[k].data);
                    end
                    if (stall_cnt >= stall) begin
                        bus.reg_ready_i = 1'b1;
                        bus.reg_error_i = (k == err_step);
                        k++;
                        stall_cnt = 0;
                    end else begin
                        bus.reg_ready_i = 1'b0;
                        bus.reg_error_i = 1'b0;
                        stall_cnt++;
                    end
                end else begin
                    bus.reg_ready_i = 1'b0;
                    bus.reg_error_i = 1'b0;
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;

        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s rsp_timeout: got no rsp_valid_o within %0d cycles expected one",
                     name, Budget);
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
            return;
        end
        n_checks++;
        if (bus.rsp_error_o !== exp_err) begin
            n_errors++;
            $display("FAIL %s rsp_error: got %b expected %b", name, bus.rsp_error_o, exp_err);
        end
        n_checks++;
        if (k != n_exp || bus.reg_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s write_count: got %0d (reg_valid %b) expected %0d (reg_valid 0)",
                     name, k, bus.reg_valid_o, n_exp);
        end
        if (stall == 0 && n_exp > 0) begin
            n_checks++;
            if (rsp_cyc != n_exp + 1) begin
                n_errors++;
                $display("FAIL %s rsp_latency: got cycle %0d expected %0d",
                         name, rsp_cyc, n_exp + 1);
            end
        end else if (n_exp == 0) begin
            n_checks++;
            if (rsp_cyc > 2) begin
                n_errors++;
                $display("FAIL %s reject_latency: got cycle %0d expected <= 2", name, rsp_cyc);
            end
        end

        bus.rsp_ready_i = (rsp_hold == 0);
        for (int i = 0; i < rsp_hold; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_error_o !== exp_err ||
                bus.cmd_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_errors++;
                $display("FAIL %s rsp_hold[%0d]: got v%b e%b cr%b b%b expected v1 e%b cr0 b1",
                         name, i, bus.rsp_valid_o, bus.rsp_error_o, bus.cmd_ready_o,
                         bus.busy_o, exp_err);
            end
            if (i == rsp_hold - 1) bus.rsp_ready_i = 1'b1;
        end
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b0;
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s back_to_idle: got v%b b%b cr%b expected v0 b0 cr1",
                     name, bus.rsp_valid_o, bus.busy_o, bus.cmd_ready_o);
        end
    endtask

    function automatic cmd_t plan_entry();
        cmd_t c;
        c.op    = 1'b0;
        c.idx   = 3'd2;
        c.first = 36'h1_0000_0010;
        c.last  = 36'h1_0000_001F;
        c.base  = 36'h0_8000_0000;
        c.vflag = 1'b1;
        c.ro    = 1'b0;
        c.en    = 1'b0;
        return c;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_error_o, bus.busy_o, bus.reg_valid_o}
                !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_flags: got cr%b v%b e%b b%b rv%b expected cr1 v0 e0 b0 rv0",
                     bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_error_o, bus.busy_o,
                     bus.reg_valid_o);
        end
        n_checks++;
        if (bus.reg_addr_o !== 32'h0 || bus.reg_wdata_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_addr_data: got %h/%h expected 0/0",
                     bus.reg_addr_o, bus.reg_wdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_entry_write();
        run_cmd("entry_write", plan_entry(), 0, -1, 0);
    endtask

    task automatic test_entry_stall();
        run_cmd("entry_stall", plan_entry(), 3, -1, 0);
    endtask

    task automatic test_entry_error();
        run_cmd("entry_error", plan_entry(), 0, 3, 0);
        run_cmd("entry_error_first", plan_entry(), 1, 0, 1);
    endtask

    task automatic test_bad_index();
        cmd_t c;
        c = plan_entry();
        c.idx = 3'd6;
        run_cmd("bad_index6", c, 0, -1, 0);
        c.idx = 3'd7;
        run_cmd("bad_index7", c, 0, -1, 2);
    endtask

    task automatic test_enable();
        cmd_t c;
        c = plan_entry();
        c.op = 1'b1;
        c.en = 1'b1;
        run_cmd("enable_on", c, 0, -1, 5);
        c.en = 1'b0;
        run_cmd("enable_off", c, 2, -1, 0);
        c.en = 1'b1;
        run_cmd("enable_error", c, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        c = plan_entry();
        c.idx = 3'd1;
        build_expected(c);
        bus.cmd_valid_i      = 1'b1;
        bus.cmd_op_i         = c.op;
        bus.cmd_idx_i        = c.idx;
        bus.cmd_first_i      = c.first;
        bus.cmd_last_i       = c.last;
        bus.cmd_base_i       = c.base;
        bus.cmd_valid_flag_i = c.vflag;
        bus.cmd_ro_i         = c.ro;
        bus.reg_ready_i      = 1'b1;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (bus.reg_valid_o !== 1'b1 || bus.reg_addr_o !== exp_q[4].addr) begin
            n_errors++;
            $display("FAIL reset_mid_step4: got v%b %h expected v1 %h",
                     bus.reg_valid_o, bus.reg_addr_o, exp_q[4].addr);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.reg_ready_i = 1'b0;
        n_checks++;
        if (bus.reg_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 ||
            bus.rsp_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_state: got rv%b b%b cr%b v%b expected rv0 b0 cr1 v0",
                     bus.reg_valid_o, bus.busy_o, bus.cmd_ready_o, bus.rsp_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (bus.rsp_valid_o !== 1'b0 || bus.reg_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_quiet[%0d]: got v%b rv%b expected v0 rv0",
                         i, bus.rsp_valid_o, bus.reg_valid_o);
            end
        end
    endtask

    task automatic test_random();
        cmd_t c;
        int   stall, err_step, hold;
        for (int n = 0; n < 40; n++) begin
            c.op    = ($urandom_range(0, 3) == 0);
            c.idx   = 3'($urandom_range(0, 7));
            c.first = PageWidth'({$urandom(), $urandom()});
            c.last  = PageWidth'({$urandom(), $urandom()});
            c.base  = PageWidth'({$urandom(), $urandom()});
            c.vflag = 1'($urandom_range(0, 1));
            c.ro    = 1'($urandom_range(0, 1));
            c.en    = 1'($urandom_range(0, 1));
            stall    = $urandom_range(0, 2);
            err_step = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            hold     = $urandom_range(0, 3);
            run_cmd($sformatf("random%0d", n), c, stall, err_step, hold);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_entry_write();
        test_entry_stall();
        test_entry_error();
        test_bad_index();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
